// File: rtl/sdram_responder.sv
// sdram_responder: behavioural SDRAM device model with protocol checking and a CAS-latency read pipeline.
// Defining SDRAM_RESPONDER_INIT_CHECK_EN rejects ACT/READ/WRITE until the first legal MRS after reset.
module sdram_responder #(
  parameter int MEM_ROW_BITS = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        sdram_cke,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_wen_n,
  input  logic [10:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic [3:0]  sdram_dqm,
  input  logic [31:0] sdram_dq_in,
  output logic [31:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        protocol_error,
  output logic [7:0]  error_count
);
  localparam int AW = 2 + MEM_ROW_BITS + 8;
  typedef enum logic [2:0] {C_NOP, C_ACT, C_READ, C_WRITE, C_PRE, C_REF, C_MRS} cmd_t;
  cmd_t cmd;
  logic [31:0] mem [2**AW];
  logic [3:0] bank_open, open_nx;
  logic [3:0][10:0] row;
  logic [2:0] cl, cl_nx;
  logic [1:0] pv;
  logic [1:0][31:0] pd;
  logic viol, wr_en, rd_go, cancel, mrs_ok, init_ok, hit;
  logic [AW-1:0] idx;
  logic [31:0] rd_data, rmask;
  logic unused_bits;
  assign unused_bits = ^{sdram_addr[9:8], sdram_addr[3], row};
  assign hit = bank_open[sdram_ba];
  assign idx = {sdram_ba, row[sdram_ba][MEM_ROW_BITS-1:0], sdram_addr[7:0]};
  assign rmask = {{8{~sdram_dqm[3]}}, {8{~sdram_dqm[2]}}, {8{~sdram_dqm[1]}}, {8{~sdram_dqm[0]}}};
  assign rd_data = hit ? (mem[idx] & rmask) : 32'h0;
  assign cancel = (cmd == C_WRITE) && init_ok;
  always_comb begin
    cmd = C_NOP;
    if (sdram_cke && !sdram_cs_n)
      case ({sdram_ras_n, sdram_cas_n, sdram_wen_n})
        3'b011: cmd = C_ACT;
        3'b101: cmd = C_READ;
        3'b100: cmd = C_WRITE;
        3'b010: cmd = C_PRE;
        3'b001: cmd = C_REF;
        3'b000: cmd = C_MRS;
        default: cmd = C_NOP;
      endcase
  end
  always_comb begin
    viol = 1'b0;
    wr_en = 1'b0;
    rd_go = 1'b0;
    open_nx = bank_open;
    cl_nx = cl;
    mrs_ok = !(|bank_open) && (sdram_addr[6:4] == 3'd2 || sdram_addr[6:4] == 3'd3) && sdram_addr[2:0] == 3'd0;
    case (cmd)
      C_ACT: begin
        viol = !init_ok || hit;
        if (init_ok) open_nx[sdram_ba] = 1'b1;
      end
      C_READ: begin
        viol = !init_ok || !hit;
        rd_go = init_ok;
        if (init_ok && sdram_addr[10]) open_nx[sdram_ba] = 1'b0;
      end
      C_WRITE: begin
        viol = !init_ok || !hit || (|pv);
        wr_en = init_ok && hit;
        if (init_ok && sdram_addr[10]) open_nx[sdram_ba] = 1'b0;
      end
      C_PRE: begin
        if (sdram_addr[10]) open_nx = '0;
        else open_nx[sdram_ba] = 1'b0;
      end
      C_REF: viol = |bank_open;
      C_MRS: begin
        viol = !mrs_ok;
        cl_nx = mrs_ok ? sdram_addr[6:4] : cl;
      end
      default: ;
    endcase
  end
`ifdef SDRAM_RESPONDER_INIT_CHECK_EN
  typedef enum logic {UNINIT, READY} init_t;
  init_t st, st_nx;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) st <= UNINIT;
    else st <= st_nx;
  always_comb st_nx = (cmd == C_MRS && mrs_ok) ? READY : st;
  assign init_ok = (st == READY);
`else
  assign init_ok = 1'b1;
`endif
  // storage deliberately has no reset so contents survive n_reset
  always_ff @(posedge clk)
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (!sdram_dqm[b]) mem[idx][8*b +: 8] <= sdram_dq_in[8*b +: 8];
  // read slots enter at depth CL-2 so the output register fires at edge N+CL-1
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      bank_open <= '0;
      row <= '0;
      cl <= 3'd2;
      pv <= '0;
      pd <= '0;
      sdram_dq_oe <= 1'b0;
      sdram_dq_out <= '0;
      protocol_error <= 1'b0;
      error_count <= '0;
    end else begin
      bank_open <= open_nx;
      cl <= cl_nx;
      if (cmd == C_ACT && init_ok) row[sdram_ba] <= sdram_addr;
      if (viol) begin
        protocol_error <= 1'b1;
        if (error_count != 8'hff) error_count <= error_count + 8'd1;
      end
      sdram_dq_oe <= pv[0] && !cancel;
      sdram_dq_out <= (pv[0] && !cancel) ? pd[0] : '0;
      pv <= cancel ? 2'b00 : {1'b0, pv[1]};
      pd <= {32'h0, pd[1]};
      if (rd_go && cl == 3'd3) begin
        pv[1] <= 1'b1;
        pd[1] <= rd_data;
      end else if (rd_go) begin
        pv[0] <= 1'b1;
        pd[0] <= rd_data;
      end
    end
endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameter MEM_ROW_BITS, default 2: low row-address bits kept in storage; storage = 4 banks x 2^MEM_ROW_BITS rows x 256 columns x 32 bit.
REQ-002 clk  input  1  sole clock; all device pins sampled on rising edge (connects to O_sdram_clk).
REQ-003 n_reset  input  1  asynchronous, active-low reset.
REQ-004 sdram_cke  input  1  clock enable; low = command ignored.
REQ-005 sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_wen_n  input  1 each  command pins.
REQ-006 sdram_addr  input  11  row address / column address (bits 7:0), A10 = auto/all precharge.
REQ-007 sdram_ba  input  2  bank select.
REQ-008 sdram_dqm  input  4  byte mask, bit n masks dq[8n+7:8n], 1 = masked.
REQ-009 sdram_dq_in  input  32  write data from controller.
REQ-010 sdram_dq_out  output  32  read data.
REQ-011 sdram_dq_oe  output  1  read data drive enable.
REQ-012 protocol_error  output  1  sticky violation flag.
REQ-013 error_count  output  8  saturating violation count.

Function
REQ-014 Command decode {ras_n,cas_n,wen_n} with cs_n=0, cke=1: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS, 110 BST (treated as NOP); cs_n=1 or cke=0 = NOP.
REQ-015 Per bank: open flag and 11-bit open row; ACT sets both; ACT to an open bank = violation, row still updated.
REQ-016 Storage index = {ba, open_row[MEM_ROW_BITS-1:0], addr[7:0]}.
REQ-017 WRITE to open bank: dq_in written in the same edge, only bytes with dqm bit 0; to closed bank = violation, no write.
REQ-018 READ to open bank: word read at command edge N; sdram_dq_oe=1 and sdram_dq_out=data for exactly one cycle, registered at edge N+CL-1, sampled by controller at edge N+CL; bytes whose dqm bit was 1 at edge N read as 8'h00.
REQ-019 READ to closed bank = violation; dq_oe still pulses with dq_out=0.
REQ-020 READ/WRITE with A10=1 close that bank after the access.
REQ-021 PRE: A10=1 closes all banks; A10=0 closes bank ba; PRE to closed bank is legal.
REQ-022 REF with any bank open = violation; otherwise no storage effect.
REQ-023 MRS: CL = addr[6:4] (2 or 3 legal); burst length addr[2:0] must be 000; MRS with any bank open, illegal CL or BL = violation, CL unchanged.
REQ-024 Read pipeline: 3-stage shift register; back-to-back READs each cycle yield dq_oe high on consecutive cycles.
REQ-025 WRITE while any read data still pending = bus-conflict violation; write executes; all pending read slots cancelled (dq_oe stays 0).
REQ-026 READ the cycle after WRITE to same address returns the newly written data.
REQ-027 Violation: protocol_error set until reset; error_count +1 per violating command, saturates at 255; one command counts once even if it violates multiple rules.

Reset
REQ-028 n_reset low asynchronously: dq_out=0, dq_oe=0, protocol_error=0, error_count=0, all banks closed, rows 0, CL=2, read pipeline empty, init state = uninitialised.
REQ-029 Reset mid-read cancels pending data; storage contents not cleared.

Configuration
REQ-030 Macro SDRAM_RESPONDER_INIT_CHECK_EN defined: ACT/READ/WRITE before first legal MRS after reset = violation and the command is ignored; NOP/PRE/REF/MRS accepted.
REQ-031 Macro undefined: no init tracking; ACT/READ/WRITE accepted immediately after reset.

Verification
REQ-032 MRS CL=2, ACT bank0 row0, WRITE col0 dq=32'h12345678 dqm=0, READ col0 at edge N -> dq_oe=1 sampled at edge N+2, dq_out=32'h12345678, error_count=0.
REQ-033 MRS CL=3, WRITE col1 32'hAABBCCDD dqm=4'b0101 over prior 0 -> READ col1 returns 32'hAA00CC00 at edge N+3.
REQ-034 READ bank1 with bank1 closed -> dq_out=0 pulse, protocol_error=1, error_count=1; then 300 such READs -> error_count=255.
REQ-035 READ col0, next cycle WRITE col2 -> violation, no dq_oe pulse, col2 updated.
REQ-036 READ with A10=1 then READ same bank without ACT -> second READ violation; PRE A10=1 then REF -> no violation.
REQ-037 With SDRAM_RESPONDER_INIT_CHECK_EN: ACT before MRS -> error_count=1, bank stays closed; without macro -> no violation, bank open.
